// File: rtl/register_write_back_unit.sv
// rtl/register_write_back_unit.sv - in-order write-back FIFO driving the register-file write port
module register_write_back_unit #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      alu_valid,
    input  logic [ADDR_WIDTH-1:0]     alu_rd,
    input  logic [DATA_WIDTH-1:0]     alu_data,
    output logic                      alu_ready,
    input  logic                      mem_valid,
    input  logic [ADDR_WIDTH-1:0]     mem_rd,
    input  logic [DATA_WIDTH-1:0]     mem_data,
    output logic                      mem_ready,
    output logic [ADDR_WIDTH-1:0]     RW,
    output logic [DATA_WIDTH-1:0]     BusW1,
    output logic [DATA_WIDTH-1:0]     BusW2,
    output logic                      sig_enable_write1,
    output logic                      sig_enable_write2,
    output logic [2**ADDR_WIDTH-1:0]  pending,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2**ADDR_WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_M1_C = CNT_W'(DEPTH - 1);

    // FIFO storage; lane bit set marks a memory-stage (lane 2) result
    logic [ADDR_WIDTH-1:0] rd_q   [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_d   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]      lane_q, lane_d;

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // Output stage presented to the register file
    logic [ADDR_WIDTH-1:0] rw_q, rw_d;
    logic [DATA_WIDTH-1:0] busw1_q, busw1_d;
    logic [DATA_WIDTH-1:0] busw2_q, busw2_d;
    logic                  we1_q, we1_d;
    logic                  we2_q, we2_d;

    logic                  push_mem, push_alu, pop;
    logic [PTR_W-1:0]      alu_slot;
    logic [NREG-1:0]       pending_c;

    // Readiness looks only at registered occupancy; a same-cycle pop never frees a slot
    assign mem_ready = !flush && (count_q < DEPTH_C);
    assign alu_ready = !flush && ((count_q < DEPTH_M1_C) || ((count_q < DEPTH_C) && !mem_valid));

    assign push_mem = mem_valid && mem_ready;
    assign push_alu = alu_valid && alu_ready;
    assign pop      = (count_q != '0) && !flush;
    assign alu_slot = tail_q + PTR_W'(push_mem);

    // Enqueue (memory result is older, so it takes the tail slot) and dequeue bookkeeping
    always_comb begin
        rd_d    = rd_q;
        data_d  = data_q;
        lane_d  = lane_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_mem) begin
            rd_d[tail_q]   = mem_rd;
            data_d[tail_q] = mem_data;
            lane_d[tail_q] = 1'b1;
        end
        if (push_alu) begin
            rd_d[alu_slot]   = alu_rd;
            data_d[alu_slot] = alu_data;
            lane_d[alu_slot] = 1'b0;
        end
        tail_d  = tail_q + PTR_W'(push_mem) + PTR_W'(push_alu);
        head_d  = head_q + PTR_W'(pop);
        count_d = count_q + CNT_W'(push_mem) + CNT_W'(push_alu) - CNT_W'(pop);
        if (flush) begin
            head_d  = tail_q;
            tail_d  = tail_q;
            count_d = '0;
        end
    end

    // Output stage: load the head on pop, otherwise drop enables and hold address/buses
    always_comb begin
        rw_d    = rw_q;
        busw1_d = busw1_q;
        busw2_d = busw2_q;
        we1_d   = 1'b0;
        we2_d   = 1'b0;
        if (pop) begin
            rw_d = rd_q[head_q];
            if (lane_q[head_q]) begin
                busw2_d = data_q[head_q];
                we2_d   = 1'b1;
            end else begin
                busw1_d = data_q[head_q];
                we1_d   = 1'b1;
            end
        end
    end

    // Hazard mask: every queued destination plus the one currently being written
    always_comb begin
        pending_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(PTR_W'(PTR_W'(i) - head_q)) < count_q) begin
                pending_c[rd_q[i]] = 1'b1;
            end
        end
        if (we1_q || we2_q) begin
            pending_c[rw_q] = 1'b1;
        end
    end

    // State registers; reset clears the queue and drops the enables immediately
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            lane_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rw_q    <= '0;
            busw1_q <= '0;
            busw2_q <= '0;
            we1_q   <= 1'b0;
            we2_q   <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            data_q  <= data_d;
            lane_q  <= lane_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rw_q    <= rw_d;
            busw1_q <= busw1_d;
            busw2_q <= busw2_d;
            we1_q   <= we1_d;
            we2_q   <= we2_d;
        end
    end

    assign RW                = rw_q;
    assign BusW1             = busw1_q;
    assign BusW2             = busw2_q;
    assign sig_enable_write1 = we1_q;
    assign sig_enable_write2 = we2_q;
    assign pending           = pending_c;
    assign count             = count_q;

endmodule

// File: tb/tb_register_write_back_unit.sv
// tb/tb_register_write_back_unit.sv - directed vector bench for register_write_back_unit
module tb_register_write_back_unit;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        alu_valid;
    logic [2:0]  alu_rd;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [2:0]  mem_rd;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic [2:0]  RW;
    logic [15:0] BusW1;
    logic [15:0] BusW2;
    logic        sig_enable_write1;
    logic        sig_enable_write2;
    logic [7:0]  pending;
    logic [2:0]  count;

    int total;
    int bad;

    register_write_back_unit #(
        .DEPTH(4),
        .DATA_WIDTH(16),
        .ADDR_WIDTH(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .alu_valid(alu_valid),
        .alu_rd(alu_rd),
        .alu_data(alu_data),
        .alu_ready(alu_ready),
        .mem_valid(mem_valid),
        .mem_rd(mem_rd),
        .mem_data(mem_data),
        .mem_ready(mem_ready),
        .RW(RW),
        .BusW1(BusW1),
        .BusW2(BusW2),
        .sig_enable_write1(sig_enable_write1),
        .sig_enable_write2(sig_enable_write2),
        .pending(pending),
        .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        fl;
        logic        av;
        logic [2:0]  ar;
        logic [15:0] ad;
        logic        mv;
        logic [2:0]  mr;
        logic [15:0] md;
        logic        e_ar;
        logic        e_mr;
        logic [2:0]  e_cnt;
        logic        e_we1;
        logic        e_we2;
        logic [2:0]  e_rw;
        logic [15:0] e_b1;
        logic [15:0] e_b2;
        logic [7:0]  e_pend;
    } vec_t;

    vec_t vt [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic fl, input logic av, input logic [2:0] ar, input logic [15:0] ad,
                          input logic mv, input logic [2:0] mr, input logic [15:0] md);
        flush     = fl;
        alu_valid = av;
        alu_rd    = ar;
        alu_data  = ad;
        mem_valid = mv;
        mem_rd    = mr;
        mem_data  = md;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);

        //        fl av ar  ad        mv mr  md       | ar mr cnt we1 we2 rw  b1        b2        pend
        // single write
        vt.push_back('{0, 1, 3'd1, 16'h0008, 0, 3'd0, 16'h0000, 1, 1, 3'd1, 0, 0, 3'd0, 16'h0000, 16'h0000, 8'h02});
        vt.push_back('{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd0, 1, 0, 3'd1, 16'h0008, 16'h0000, 8'h02});
        vt.push_back('{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd0, 0, 0, 3'd1, 16'h0008, 16'h0000, 8'h00});
        // dual lane, same edge
        vt.push_back('{0, 1, 3'd3, 16'h0020, 1, 3'd2, 16'h0010, 1, 1, 3'd2, 0, 0, 3'd1, 16'h0008, 16'h0000, 8'h0C});
        vt.push_back('{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd1, 0, 1, 3'd2, 16'h0008, 16'h0010, 8'h0C});
        vt.push_back('{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd0, 1, 0, 3'd3, 16'h0020, 16'h0010, 8'h08});
        vt.push_back('{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd0, 0, 0, 3'd3, 16'h0020, 16'h0010, 8'h00});
        // overwrite of r2
        vt.push_back('{0, 1, 3'd2, 16'h0020, 0, 3'd0, 16'h0000, 1, 1, 3'd1, 0, 0, 3'd3, 16'h0020, 16'h0010, 8'h04});
        vt.push_back('{0, 0, 3'd0, 16'h0000, 1, 3'd2, 16'h0040, 1, 1, 3'd1, 1, 0, 3'd2, 16'h0020, 16'h0010, 8'h04});
        vt.push_back('{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd0, 0, 1, 3'd2, 16'h0020, 16'h0040, 8'h04});
        vt.push_back('{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd0, 0, 0, 3'd2, 16'h0020, 16'h0040, 8'h00});
        // back-pressure: both valid four cycles, ALU stalls at count 3 and holds its result
        vt.push_back('{0, 1, 3'd5, 16'h0105, 1, 3'd4, 16'h0104, 1, 1, 3'd2, 0, 0, 3'd2, 16'h0020, 16'h0040, 8'h30});
        vt.push_back('{0, 1, 3'd7, 16'h0107, 1, 3'd6, 16'h0106, 1, 1, 3'd3, 0, 1, 3'd4, 16'h0020, 16'h0104, 8'hF0});
        vt.push_back('{0, 1, 3'd1, 16'h0101, 1, 3'd0, 16'h0100, 0, 1, 3'd3, 1, 0, 3'd5, 16'h0105, 16'h0104, 8'hE1});
        vt.push_back('{0, 1, 3'd1, 16'h0101, 1, 3'd3, 16'h0103, 0, 1, 3'd3, 0, 1, 3'd6, 16'h0105, 16'h0106, 8'hC9});
        vt.push_back('{0, 1, 3'd1, 16'h0101, 0, 3'd0, 16'h0000, 1, 1, 3'd3, 1, 0, 3'd7, 16'h0107, 16'h0106, 8'h8B});
        vt.push_back('{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd2, 0, 1, 3'd0, 16'h0107, 16'h0100, 8'h0B});
        vt.push_back('{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd1, 0, 1, 3'd3, 16'h0107, 16'h0103, 8'h0A});
        vt.push_back('{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd0, 1, 0, 3'd1, 16'h0101, 16'h0103, 8'h02});
        vt.push_back('{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd0, 0, 0, 3'd1, 16'h0101, 16'h0103, 8'h00});
        // flush with three entries queued, inputs offered during flush must be ignored
        vt.push_back('{0, 1, 3'd5, 16'h0205, 1, 3'd4, 16'h0204, 1, 1, 3'd2, 0, 0, 3'd1, 16'h0101, 16'h0103, 8'h30});
        vt.push_back('{0, 1, 3'd7, 16'h0207, 1, 3'd6, 16'h0206, 1, 1, 3'd3, 0, 1, 3'd4, 16'h0101, 16'h0204, 8'hF0});
        vt.push_back('{1, 1, 3'd0, 16'h0300, 1, 3'd1, 16'h0301, 0, 0, 3'd0, 0, 0, 3'd4, 16'h0101, 16'h0204, 8'h00});
        vt.push_back('{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd0, 0, 0, 3'd4, 16'h0101, 16'h0204, 8'h00});
        vt.push_back('{0, 1, 3'd2, 16'h0302, 0, 3'd0, 16'h0000, 1, 1, 3'd1, 0, 0, 3'd4, 16'h0101, 16'h0204, 8'h04});
        vt.push_back('{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd0, 1, 0, 3'd2, 16'h0302, 16'h0204, 8'h04});
        vt.push_back('{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd0, 0, 0, 3'd2, 16'h0302, 16'h0204, 8'h00});

        // reset state
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_we1", 32'(sig_enable_write1), 32'd0);
        chk("rst_we2", 32'(sig_enable_write2), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_rw", 32'(RW), 32'd0);
        chk("rst_busw1", 32'(BusW1), 32'd0);
        chk("rst_busw2", 32'(BusW2), 32'd0);
        #9;
        reset = 1'b1;
        #1;
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);

        for (int i = 0; i < vt.size(); i++) begin
            set_in(vt[i].fl, vt[i].av, vt[i].ar, vt[i].ad, vt[i].mv, vt[i].mr, vt[i].md);
            #1;
            chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vt[i].e_ar));
            chk($sformatf("v%0d_mem_ready", i), 32'(mem_ready), 32'(vt[i].e_mr));
            tick();
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].e_cnt));
            chk($sformatf("v%0d_we1", i), 32'(sig_enable_write1), 32'(vt[i].e_we1));
            chk($sformatf("v%0d_we2", i), 32'(sig_enable_write2), 32'(vt[i].e_we2));
            chk($sformatf("v%0d_rw", i), 32'(RW), 32'(vt[i].e_rw));
            chk($sformatf("v%0d_busw1", i), 32'(BusW1), 32'(vt[i].e_b1));
            chk($sformatf("v%0d_busw2", i), 32'(BusW2), 32'(vt[i].e_b2));
            chk($sformatf("v%0d_pending", i), 32'(pending), 32'(vt[i].e_pend));
            chk($sformatf("v%0d_one_enable", i), 32'(sig_enable_write1 & sig_enable_write2), 32'd0);
        end

        // async reset in the middle of retirement
        set_in(0, 1, 3'd6, 16'h0406, 1, 3'd5, 16'h0405);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        chk("ar_count_pre", 32'(count), 32'd2);
        tick();
        chk("ar_we2_pre", 32'(sig_enable_write2), 32'd1);
        chk("ar_rw_pre", 32'(RW), 32'd5);
        reset = 1'b0;
        #1;
        chk("ar_we1", 32'(sig_enable_write1), 32'd0);
        chk("ar_we2", 32'(sig_enable_write2), 32'd0);
        chk("ar_pending", 32'(pending), 32'd0);
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_rw", 32'(RW), 32'd0);
        chk("ar_busw2", 32'(BusW2), 32'd0);
        #1;
        reset = 1'b1;
        set_in(0, 1, 3'd3, 16'h0505, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        chk("ar_post_count", 32'(count), 32'd1);
        chk("ar_post_we1_early", 32'(sig_enable_write1), 32'd0);
        tick();
        chk("ar_post_we1", 32'(sig_enable_write1), 32'd1);
        chk("ar_post_rw", 32'(RW), 32'd3);
        chk("ar_post_busw1", 32'(BusW1), 32'h0505);
        chk("ar_post_pending", 32'(pending), 32'h08);
        tick();
        chk("ar_end_we1", 32'(sig_enable_write1), 32'd0);
        chk("ar_end_pending", 32'(pending), 32'd0);
        chk("ar_end_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
